// File: rtl/drag_reaction_timer_pkg.sv
// Shared types and constants for the drag-race reaction timer.
// Holds the FSM state encoding and the saturating 4-digit BCD increment.
package drag_reaction_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_TIMING    = 3'd3,
    ST_DONE      = 3'd4,
    ST_FOUL      = 3'd5
  } state_t;

  localparam int          TICK_DIV_SIM = 10;
  localparam logic [15:0] BCD_MAX      = 16'h9999;

  // Ripple a +1 through four BCD digits; 9999 is a fixed point so the result never wraps.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD_MAX) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (r[d*4 +: 4] == 4'd9) begin
            r[d*4 +: 4] = 4'd0;
          end else begin
            r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/drag_reaction_timer_if.sv
// Tree-light / stage-beam inputs and result outputs of the reaction timer.
// Every signal here is sampled or updated on the rising edge of the shared clock.
interface drag_reaction_timer_if;
  import drag_reaction_timer_pkg::*;

  logic        SL;
  logic        A1;
  logic        G;
  logic        R;
  logic        SB;
  logic [15:0] RT_BCD;
  logic        Valid;
  logic        Foul;
  logic        Busy;
  state_t      state;

  // Tree controller / board side drives the lights and beam and observes results.
  modport master (
    output SL, A1, G, R, SB,
    input  RT_BCD, Valid, Foul, Busy, state
  );

  modport slave (
    input  SL, A1, G, R, SB,
    output RT_BCD, Valid, Foul, Busy, state
  );

endinterface

// File: rtl/drag_reaction_timer_bcd_counter4.sv
// Four-digit BCD millisecond counter with synchronous clear and saturating increment.
// Clear has priority over increment.
module drag_reaction_timer_bcd_counter4
  import drag_reaction_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= 16'h0000;
    end else if (inc) begin
      value <= bcd_inc(value);
    end
  end

endmodule

// File: rtl/drag_reaction_timer.sv
// Measures driver reaction time from green rising to the car leaving the stage beam,
// and flags fouls for an early leave or a red light.
module drag_reaction_timer
  import drag_reaction_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int TICK_W   = 16
) (
  input logic               CLOCK_50,
  input logic               Reset,
  drag_reaction_timer_if.slave tree
);

  state_t            state;
  logic              a1_q;
  logic              g_q;
  logic [TICK_W-1:0] presc;
  logic              valid_r;
  logic              foul_r;
  logic              busy_r;
  logic              cnt_clr;
  logic              cnt_inc;
  logic [15:0]       rt_bcd;
  logic              a1_rise;
  logic              g_rise;
  logic              tick;
  logic              arm_req;

  assign a1_rise = tree.A1 & ~a1_q;
  assign g_rise  = tree.G & ~g_q;
  assign tick    = (presc == TICK_W'(TICK_DIV - 1));
  assign arm_req = tree.SL & tree.SB;

  // Counter control mirrors the FSM branches: clear on entry to ARMED or TIMING,
  // increment only on a tick that is not pre-empted by SB dropping or red.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FOUL: cnt_clr = arm_req;
      ST_COUNTDOWN:              cnt_clr = tree.SB & ~tree.R & g_rise;
      ST_TIMING:                 cnt_inc = tree.SB & ~tree.R & tick;
      default:                   cnt_clr = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state   <= ST_IDLE;
      a1_q    <= 1'b0;
      g_q     <= 1'b0;
      presc   <= '0;
      valid_r <= 1'b0;
      foul_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      a1_q <= tree.A1;
      g_q  <= tree.G;
      case (state)
        ST_IDLE: begin
          if (arm_req) begin
            state   <= ST_ARMED;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
            foul_r  <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (!tree.SB) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end else if (a1_rise) begin
            state <= ST_COUNTDOWN;
          end
        end
        // A foul condition beats a green edge arriving in the same cycle.
        ST_COUNTDOWN: begin
          if (!tree.SB || tree.R) begin
            state  <= ST_FOUL;
            foul_r <= 1'b1;
            busy_r <= 1'b0;
          end else if (g_rise) begin
            state <= ST_TIMING;
            presc <= '0;
          end
        end
        ST_TIMING: begin
          if (!tree.SB) begin
            state   <= ST_DONE;
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
          end else if (tree.R) begin
            state  <= ST_FOUL;
            foul_r <= 1'b1;
            busy_r <= 1'b0;
          end else if (tick) begin
            presc <= '0;
          end else begin
            presc <= presc + TICK_W'(1);
          end
        end
        ST_DONE, ST_FOUL: begin
          if (arm_req) begin
            state   <= ST_ARMED;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
            foul_r  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_r <= 1'b0;
          foul_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  drag_reaction_timer_bcd_counter4 u_bcd (
    .clk   (CLOCK_50),
    .rst   (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .value (rt_bcd)
  );

  assign tree.RT_BCD = rt_bcd;
  assign tree.Valid  = valid_r;
  assign tree.Foul   = foul_r;
  assign tree.Busy   = busy_r;
  assign tree.state  = state;

endmodule

// File: tb/tb_drag_reaction_timer.sv
// Directed bench for the reaction timer: one DUT at the simulation tick rate and
// one with a one-cycle tick so the 9999 saturation point is reachable quickly.
module tb_drag_reaction_timer;
  import drag_reaction_timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #10 clk = ~clk;

  drag_reaction_timer_if t ();
  drag_reaction_timer_if s ();

  drag_reaction_timer #(.TICK_DIV(TICK_DIV_SIM), .TICK_W(16)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .tree     (t.slave)
  );

  drag_reaction_timer #(.TICK_DIV(1), .TICK_W(16)) dut_sat (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .tree     (s.slave)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] rt, input logic v,
                         input logic f, input logic b, input state_t st);
    chk({tag, "_rt"},    t.RT_BCD, rt);
    chk({tag, "_valid"}, 16'(t.Valid), 16'(v));
    chk({tag, "_foul"},  16'(t.Foul),  16'(f));
    chk({tag, "_busy"},  16'(t.Busy),  16'(b));
    chk({tag, "_state"}, 16'(t.state), 16'(st));
  endtask

  initial begin
    {t.SL, t.A1, t.G, t.R, t.SB} = '0;
    {s.SL, s.A1, s.G, s.R, s.SB} = '0;

    // Reset
    rst = 1'b1;
    cyc(5);
    rst = 1'b0;
    chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0, ST_IDLE);

    // Normal run: 370 cycles in TIMING -> 37 ms
    t.SL = 1'b1; t.SB = 1'b1; cyc(1);
    chk_out("armed", 16'h0000, 1'b0, 1'b0, 1'b1, ST_ARMED);
    t.A1 = 1'b1; cyc(1); t.A1 = 1'b0;
    chk("countdown_state", 16'(t.state), 16'(ST_COUNTDOWN));
    cyc(3);
    t.G = 1'b1; cyc(1);
    chk_out("timing_entry", 16'h0000, 1'b0, 1'b0, 1'b1, ST_TIMING);
    cyc(369);
    chk("run_369", t.RT_BCD, 16'h0036);
    cyc(1);
    chk("run_370", t.RT_BCD, 16'h0037);
    t.SB = 1'b0; cyc(1);
    chk_out("done", 16'h0037, 1'b1, 1'b0, 1'b0, ST_DONE);
    t.G = 1'b0; cyc(3);
    chk_out("done_hold", 16'h0037, 1'b1, 1'b0, 1'b0, ST_DONE);

    // Early leave before green; a later green is ignored
    t.SB = 1'b1; cyc(1);
    chk_out("rearm", 16'h0000, 1'b0, 1'b0, 1'b1, ST_ARMED);
    t.A1 = 1'b1; cyc(1); t.A1 = 1'b0;
    t.SB = 1'b0; cyc(1);
    chk_out("early", 16'h0000, 1'b0, 1'b1, 1'b0, ST_FOUL);
    t.G = 1'b1; cyc(5);
    chk_out("early_g_ignored", 16'h0000, 1'b0, 1'b1, 1'b0, ST_FOUL);
    t.G = 1'b0;

    // SB drops in the same cycle as the green edge
    t.SB = 1'b1; cyc(1);
    chk_out("rearm2", 16'h0000, 1'b0, 1'b0, 1'b1, ST_ARMED);
    t.A1 = 1'b1; cyc(1); t.A1 = 1'b0;
    cyc(1);
    t.G = 1'b1; t.SB = 1'b0; cyc(1);
    chk_out("sb_with_g", 16'h0000, 1'b0, 1'b1, 1'b0, ST_FOUL);

    // Red during TIMING holds the value reached
    t.G = 1'b0; t.SB = 1'b1; cyc(1);
    t.A1 = 1'b1; cyc(1); t.A1 = 1'b0;
    cyc(1);
    t.G = 1'b1; cyc(1);
    cyc(55);
    chk("red_pre", t.RT_BCD, 16'h0005);
    t.R = 1'b1; cyc(1);
    chk_out("red_foul", 16'h0005, 1'b0, 1'b1, 1'b0, ST_FOUL);

    // Back-out from ARMED
    t.R = 1'b0; t.G = 1'b0; cyc(1);
    chk_out("arm_from_foul", 16'h0000, 1'b0, 1'b0, 1'b1, ST_ARMED);
    t.SB = 1'b0; cyc(1);
    chk_out("backout", 16'h0000, 1'b0, 1'b0, 1'b0, ST_IDLE);

    // Reset in the middle of TIMING
    t.SB = 1'b1; cyc(1);
    t.A1 = 1'b1; cyc(1); t.A1 = 1'b0;
    cyc(1);
    t.G = 1'b1; cyc(1);
    cyc(25);
    chk("mid_timing", t.RT_BCD, 16'h0002);
    rst = 1'b1; cyc(1);
    chk_out("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0, ST_IDLE);
    rst = 1'b0;
    {t.SL, t.A1, t.G, t.R, t.SB} = '0;

    // Saturation on the one-cycle-tick instance
    s.SL = 1'b1; s.SB = 1'b1; cyc(1);
    s.A1 = 1'b1; cyc(1); s.A1 = 1'b0;
    cyc(1);
    s.G = 1'b1; cyc(1);
    chk("sat_state", 16'(s.state), 16'(ST_TIMING));
    cyc(1234);
    chk("sat_1234", s.RT_BCD, 16'h1234);
    cyc(8764);
    chk("sat_9998", s.RT_BCD, 16'h9998);
    cyc(1);
    chk("sat_9999", s.RT_BCD, 16'h9999);
    cyc(100);
    chk("sat_hold", s.RT_BCD, 16'h9999);
    s.SB = 1'b0; cyc(1);
    chk("sat_valid", 16'(s.Valid), 16'd1);
    chk("sat_foul", 16'(s.Foul), 16'd0);
    chk("sat_rt", s.RT_BCD, 16'h9999);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
